// File: rtl/xe1ap_pkg.sv
// Shared types and constants for the XE-1AP host reader: FSM states, frame
// nybble positions and the button bit layout of the decoded output vector.
package xe1ap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LOW,
    CAPTURE,
    CHECK,
    DRAIN,
    ABORT
  } state_t;

  typedef logic [3:0] nybble_t;

  localparam int NUM_NYB  = 12;
  localparam int NYB_BTN1 = 0;
  localparam int NYB_BTN2 = 1;
  localparam int NYB_Y_HI = 2;
  localparam int NYB_X_HI = 3;
  localparam int NYB_T_HI = 4;
  localparam int NYB_PAD0 = 5;
  localparam int NYB_Y_LO = 6;
  localparam int NYB_X_LO = 7;
  localparam int NYB_T_LO = 8;
  localparam int NYB_PAD1 = 9;
  localparam int NYB_BTN3 = 10;
  localparam int NYB_END  = 11;

  localparam nybble_t END_NYBBLE = 4'hF;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_C      = 2;
  localparam int BTN_D      = 3;
  localparam int BTN_E1     = 4;
  localparam int BTN_E2     = 5;
  localparam int BTN_START  = 6;
  localparam int BTN_SELECT = 7;
  localparam int BTN_A2     = 8;
  localparam int BTN_B2     = 9;
  localparam int BTN_AP     = 10;
  localparam int BTN_BP     = 11;

  // Pad lines are active-low; within each group nybble bit 3 is the lowest button.
  function automatic logic [11:0] decode_buttons(input nybble_t b1, input nybble_t b2,
                                                 input nybble_t b3);
    logic [11:0] pressed;
    pressed             = '0;
    pressed[BTN_A]      = ~b1[3];
    pressed[BTN_B]      = ~b1[2];
    pressed[BTN_C]      = ~b1[1];
    pressed[BTN_D]      = ~b1[0];
    pressed[BTN_E1]     = ~b2[3];
    pressed[BTN_E2]     = ~b2[2];
    pressed[BTN_START]  = ~b2[0];
    pressed[BTN_SELECT] = ~b2[1];
    pressed[BTN_A2]     = ~b3[3];
    pressed[BTN_B2]     = ~b3[2];
    pressed[BTN_AP]     = ~b3[1];
    pressed[BTN_BP]     = ~b3[0];
    return pressed;
  endfunction

endpackage

// File: rtl/xe1ap_host_if.sv
// Connection bundle between core logic, the pad connector and xe1ap_host.
// master = the side driving start/pad lines, slave = the host reader itself.
interface xe1ap_host_if;
  logic        start;
  logic [1:0]  speed_sel;
  logic        ack_in;
  logic        lo_hi_in;
  logic [3:0]  data_in;
  logic        req;
  logic        busy;
  logic        valid;
  logic        frame_err;
  logic [11:0] buttons;
  logic [7:0]  ch0_y;
  logic [7:0]  ch1_x;
  logic [7:0]  ch2_thr;

  modport master (
    output start, speed_sel, ack_in, lo_hi_in, data_in,
    input  req, busy, valid, frame_err, buttons, ch0_y, ch1_x, ch2_thr
  );

  modport slave (
    input  start, speed_sel, ack_in, lo_hi_in, data_in,
    output req, busy, valid, frame_err, buttons, ch0_y, ch1_x, ch2_thr
  );
endinterface

// File: rtl/xe1ap_usec_timer.sv
// Microsecond timebase: a 0..CLKPERUSEC-1 prescaler feeding a saturating
// microsecond counter; clr_i restarts both from zero.
module xe1ap_usec_timer #(
  parameter int CLKPERUSEC = 50,
  parameter int CNT_W      = 9
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             clr_i,
  output logic [CNT_W-1:0] usec_o
);

  localparam int PRE_W = (CLKPERUSEC > 1) ? $clog2(CLKPERUSEC) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] usec_q, usec_d;
  logic             tick;

  assign tick = (pre_q == PRE_W'(CLKPERUSEC - 1));

  always_comb begin
    pre_d  = tick ? '0 : pre_q + 1'b1;
    usec_d = usec_q;
    if (tick && (usec_q != '1)) begin
      usec_d = usec_q + 1'b1;
    end
    if (clr_i) begin
      pre_d  = '0;
      usec_d = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pre_q  <= '0;
      usec_q <= '0;
    end else begin
      pre_q  <= pre_d;
      usec_q <= usec_d;
    end
  end

  assign usec_o = usec_q;

endmodule

// File: rtl/xe1ap_host.sv
// XE-1AP / CyberStick host reader: drives REQ, captures the 12-nybble frame
// and decodes it. Optional auto-poll is enabled by XE1AP_HOST_AUTOPOLL_EN.
module xe1ap_host
  import xe1ap_pkg::*;
#(
  parameter int CLKPERUSEC = 50,
  parameter int REQ_MIN_US = 4,
  parameter int TIMEOUT_US = 250
`ifdef XE1AP_HOST_AUTOPOLL_EN
  , parameter int POLL_US  = 16000
`endif
) (
  input  logic         clk_sys,
  input  logic         reset,
  xe1ap_host_if.slave  bus
);

  localparam logic [8:0] REQ_MIN_CNT = 9'(REQ_MIN_US);
  localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT_US);
  // Pin order {lo_hi, ack, data[3:0]}; ACK idles high.
  localparam logic [5:0] PIN_IDLE = 6'b01_0000;

  state_t      state_q, state_d;
  logic [5:0]  pin_s1_q, pin_s2_q;
  logic        ack_dly_q;
  logic        ack_s, lohi_s, ack_fall;
  logic [3:0]  data_s;

  logic [3:0]  n_q, n_d;
  logic [1:0]  speed_q, speed_d;
  logic        mism_q, mism_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic [11:0] buttons_q, buttons_d;
  logic [7:0]  y_q, y_d, x_q, x_d, thr_q, thr_d;

  nybble_t     nyb_q [NUM_NYB];
  logic [NUM_NYB-1:0] nyb_ld;

  logic [8:0]  usec;
  logic        tmr_clr, timed_out, cap_stb, frame_ok, drain_done, start_eff;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pin_s1_q  <= PIN_IDLE;
      pin_s2_q  <= PIN_IDLE;
      ack_dly_q <= 1'b1;
    end else begin
      pin_s1_q  <= {bus.lo_hi_in, bus.ack_in, bus.data_in};
      pin_s2_q  <= pin_s1_q;
      ack_dly_q <= pin_s2_q[4];
    end
  end

  assign data_s   = pin_s2_q[3:0];
  assign ack_s    = pin_s2_q[4];
  assign lohi_s   = pin_s2_q[5];
  assign ack_fall = ack_dly_q & ~ack_s;

  assign cap_stb    = (state_q == CAPTURE) && ack_fall;
  assign timed_out  = (usec >= TIMEOUT_CNT);
  assign drain_done = (ack_s && !lohi_s) || timed_out;
  assign frame_ok   = (nyb_q[NYB_PAD0] == 4'h0) && (nyb_q[NYB_PAD1] == 4'h0) &&
                      (nyb_q[NYB_END] == END_NYBBLE) && !mism_q;

  // Every state change and every captured nybble restarts the shared timebase.
  assign tmr_clr = (state_d != state_q) || cap_stb;

  xe1ap_usec_timer #(
    .CLKPERUSEC (CLKPERUSEC),
    .CNT_W      (9)
  ) u_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr_i   (tmr_clr),
    .usec_o  (usec)
  );

`ifdef XE1AP_HOST_AUTOPOLL_EN
  localparam int POLL_W = $clog2(POLL_US + 1);
  logic [POLL_W-1:0] poll_usec;

  // Held clear while a frame is in flight, so the period restarts at completion.
  xe1ap_usec_timer #(
    .CLKPERUSEC (CLKPERUSEC),
    .CNT_W      (POLL_W)
  ) u_poll_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr_i   (state_q != IDLE),
    .usec_o  (poll_usec)
  );

  assign start_eff = bus.start || ((state_q == IDLE) && (poll_usec >= POLL_W'(POLL_US)));
`else
  assign start_eff = bus.start;
`endif

  for (genvar gi = 0; gi < NUM_NYB; gi++) begin : g_nyb_ld
    assign nyb_ld[gi] = cap_stb && (n_q == 4'(gi));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < NUM_NYB; i++) nyb_q[i] <= 4'h0;
    end else begin
      for (int i = 0; i < NUM_NYB; i++) begin
        if (nyb_ld[i]) nyb_q[i] <= data_s;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_eff) state_d = REQ_LOW;
      REQ_LOW: if (usec >= REQ_MIN_CNT) state_d = CAPTURE;
      CAPTURE: begin
        if (ack_fall) begin
          if (n_q == 4'(NYB_END)) state_d = CHECK;
        end else if (timed_out) begin
          state_d = ABORT;
        end
      end
      CHECK:   state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      ABORT:   state_d = DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_d       = n_q;
    speed_d   = speed_q;
    mism_d    = mism_q;
    req_d     = req_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    buttons_d = buttons_q;
    y_d       = y_q;
    x_d       = x_q;
    thr_d     = thr_q;
    unique case (state_q)
      IDLE: begin
        if (start_eff) begin
          n_d     = '0;
          speed_d = bus.speed_sel;
          mism_d  = 1'b0;
          req_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      CAPTURE: begin
        if (ack_fall) begin
          n_d = n_q + 1'b1;
          if (lohi_s != n_q[0]) mism_d = 1'b1;
          // Releasing REQ here makes the pad see it high at its speed check.
          if (n_q == {1'b0, speed_q, 1'b0}) req_d = 1'b1;
        end
      end
      CHECK: begin
        req_d = 1'b1;
        if (frame_ok) begin
          valid_d   = 1'b1;
          y_d       = {nyb_q[NYB_Y_HI], nyb_q[NYB_Y_LO]};
          x_d       = {nyb_q[NYB_X_HI], nyb_q[NYB_X_LO]};
          thr_d     = {nyb_q[NYB_T_HI], nyb_q[NYB_T_LO]};
          buttons_d = decode_buttons(nyb_q[NYB_BTN1], nyb_q[NYB_BTN2], nyb_q[NYB_BTN3]);
        end else begin
          ferr_d = 1'b1;
        end
      end
      DRAIN:   if (drain_done) busy_d = 1'b0;
      ABORT: begin
        req_d  = 1'b1;
        ferr_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      n_q       <= '0;
      speed_q   <= '0;
      mism_q    <= 1'b0;
      req_q     <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      buttons_q <= '0;
      y_q       <= 8'h80;
      x_q       <= 8'h80;
      thr_q     <= 8'h80;
    end else begin
      n_q       <= n_d;
      speed_q   <= speed_d;
      mism_q    <= mism_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      buttons_q <= buttons_d;
      y_q       <= y_d;
      x_q       <= x_d;
      thr_q     <= thr_d;
    end
  end

  assign bus.req       = req_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.buttons   = buttons_q;
  assign bus.ch0_y     = y_q;
  assign bus.ch1_x     = x_q;
  assign bus.ch2_thr   = thr_q;

endmodule

// File: tb/tb_xe1ap_host.sv
// Bench for xe1ap_host: a pad model replays frames built from axis/button
// values; a monitor checks every valid/frame_err pulse against a scoreboard.
module tb_xe1ap_host;

  localparam int CPU     = 10;
  localparam int REQ_MIN = 4;
  localparam int TMO     = 250;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xe1ap_host_if bif();

  xe1ap_host #(
    .CLKPERUSEC (CPU),
    .REQ_MIN_US (REQ_MIN),
    .TIMEOUT_US (TMO)
  ) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bif)
  );

  typedef struct {
    bit          ok;
    logic [7:0]  y;
    logic [7:0]  x;
    logic [7:0]  t;
    logic [11:0] btn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   err_cyc = 0;
  int   txn   = 0;

  // Reference output state: what the outputs should show after the last good frame.
  logic [7:0]  last_y = 8'h80, last_x = 8'h80, last_t = 8'h80;
  logic [11:0] last_b = 12'h000;

  // Where each button lives on the wire (nybble, bit); lines are active-low.
  int btn_nyb [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 10, 10, 10, 10};
  int btn_bit [12] = '{3, 2, 1, 0, 3, 2, 0, 1, 3, 2, 1, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bif.valid === 1'b1 || bif.frame_err === 1'b1) begin
      if (bif.frame_err === 1'b1) err_cyc = cyc;
      chk("pulse_exclusive", {31'b0, bif.valid & bif.frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: valid=%b frame_err=%b with nothing expected",
                 bif.valid, bif.frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        txn++;
        $display("txn %0d: %s y=%h x=%h thr=%h btn=%h", txn,
                 bif.valid ? "valid" : "frame_err", bif.ch0_y, bif.ch1_x, bif.ch2_thr,
                 bif.buttons);
        chk("pulse_kind_valid", {31'b0, bif.valid}, {31'b0, mon_e.ok});
        chk("ch0_y", {24'b0, bif.ch0_y}, {24'b0, mon_e.y});
        chk("ch1_x", {24'b0, bif.ch1_x}, {24'b0, mon_e.x});
        chk("ch2_thr", {24'b0, bif.ch2_thr}, {24'b0, mon_e.t});
        chk("buttons", {20'b0, bif.buttons}, {20'b0, mon_e.btn});
      end
    end
  end

  // err_kind: 0 clean, 1 end nybble=E, 2 LO_HI flipped, 3 pad0 nonzero, 4 pad1 nonzero.
  task automatic run_frame(input logic [1:0] spd, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] t, input logic [11:0] btn, input int err_kind,
                           input int stop_after, input int rst_at);
    logic [3:0] nyb [12];
    exp_t       e;
    int         flip_k;
    int         last_fall;
    int         delta;

    for (int i = 0; i < 12; i++) nyb[i] = 4'h0;
    nyb[0]  = 4'hF;
    nyb[1]  = 4'hF;
    nyb[10] = 4'hF;
    for (int b = 0; b < 12; b++) begin
      if (btn[b]) nyb[btn_nyb[b]][btn_bit[b]] = 1'b0;
    end
    nyb[2]  = y[7:4];  nyb[6] = y[3:0];
    nyb[3]  = x[7:4];  nyb[7] = x[3:0];
    nyb[4]  = t[7:4];  nyb[8] = t[3:0];
    nyb[11] = 4'hF;
    flip_k  = $urandom_range(0, 11);
    if (err_kind == 1) nyb[11] = 4'hE;
    if (err_kind == 3) nyb[5]  = 4'($urandom_range(1, 15));
    if (err_kind == 4) nyb[9]  = 4'($urandom_range(1, 15));

    if (rst_at < 0) begin
      if (stop_after >= 12 && err_kind == 0) begin
        last_y = y; last_x = x; last_t = t; last_b = btn;
        e.ok = 1'b1;
      end else begin
        e.ok = 1'b0;
      end
      e.y = last_y; e.x = last_x; e.t = last_t; e.btn = last_b;
      exp_q.push_back(e);
    end

    bif.speed_sel = spd;
    bif.start     = 1'b1;
    tick();
    bif.start     = 1'b0;
    for (int w = 0; w < 20 && bif.req !== 1'b0; w++) tick();
    chk("req_low_after_start", {31'b0, bif.req}, 32'd0);
    chk("busy_after_start", {31'b0, bif.busy}, 32'd1);
    repeat (REQ_MIN * CPU + 10) tick();

    last_fall = cyc;
    for (int k = 0; k < stop_after; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        chk("rst_req", {31'b0, bif.req}, 32'd1);
        chk("rst_busy", {31'b0, bif.busy}, 32'd0);
        chk("rst_valid", {31'b0, bif.valid}, 32'd0);
        chk("rst_ferr", {31'b0, bif.frame_err}, 32'd0);
        chk("rst_y", {24'b0, bif.ch0_y}, 32'h80);
        chk("rst_x", {24'b0, bif.ch1_x}, 32'h80);
        chk("rst_thr", {24'b0, bif.ch2_thr}, 32'h80);
        chk("rst_btn", {20'b0, bif.buttons}, 32'd0);
        rst = 1'b0;
        last_y = 8'h80; last_x = 8'h80; last_t = 8'h80; last_b = 12'h000;
        break;
      end
      if (k == 2) bif.speed_sel = 2'($urandom_range(0, 3));
      if (k == 3) begin
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
      end
      bif.data_in  = nyb[k];
      bif.lo_hi_in = (k % 2 == 1) ^ (err_kind == 2 && k == flip_k);
      repeat (3) tick();
      bif.ack_in = 1'b0;
      last_fall  = cyc;
      repeat (5) tick();
      chk("req_release", {31'b0, bif.req}, (k >= 2 * spd) ? 32'd1 : 32'd0);
      bif.ack_in = 1'b1;
      repeat (3 + 2 * spd) tick();
    end
    bif.ack_in   = 1'b1;
    bif.lo_hi_in = 1'b0;

    for (int w = 0; w < 2 * TMO * CPU + 200 && bif.busy !== 1'b0; w++) tick();
    repeat (2) tick();
    chk("busy_clear", {31'b0, bif.busy}, 32'd0);
    chk("req_idle", {31'b0, bif.req}, 32'd1);
    chk("resp_delivered", exp_q.size(), 32'd0);
    if (stop_after < 12) begin
      delta = err_cyc - last_fall;
      chk("timeout_window", {31'b0, (delta >= TMO * CPU) && (delta <= TMO * CPU + 20)}, 32'd1);
    end
  endtask

  initial begin
    int busy_cnt;
    bif.start     = 1'b0;
    bif.speed_sel = 2'd0;
    bif.ack_in    = 1'b1;
    bif.lo_hi_in  = 1'b0;
    bif.data_in   = 4'h0;
    rst           = 1'b1;
    repeat (3) tick();
    chk("reset_req", {31'b0, bif.req}, 32'd1);
    chk("reset_busy", {31'b0, bif.busy}, 32'd0);
    chk("reset_valid", {31'b0, bif.valid}, 32'd0);
    chk("reset_ferr", {31'b0, bif.frame_err}, 32'd0);
    chk("reset_btn", {20'b0, bif.buttons}, 32'd0);
    chk("reset_y", {24'b0, bif.ch0_y}, 32'h80);
    chk("reset_x", {24'b0, bif.ch1_x}, 32'h80);
    chk("reset_thr", {24'b0, bif.ch2_thr}, 32'h80);
    rst = 1'b0;
    repeat (3) tick();

    run_frame(2'd3, 8'h12, 8'hA5, 8'hF0, 12'h101, 0, 12, -1);
    run_frame(2'd0, 8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom), 0, 12, -1);
    for (int i = 0; i < 6; i++) begin
      run_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
                12'($urandom), (i % 3 == 2) ? $urandom_range(1, 4) : 0, 12, -1);
    end
    run_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
              12'($urandom), 0, 5, -1);
    run_frame(2'd3, 8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom), 1, 12, -1);
    run_frame(2'd2, 8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom), 2, 12, -1);
    run_frame(2'd3, 8'h33, 8'h44, 8'h55, 12'h0F0, 0, 12, 7);
    run_frame(2'd1, 8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom), 0, 12, -1);

    busy_cnt = 0;
    for (int w = 0; w < 400; w++) begin
      tick();
      if (bif.busy !== 1'b0 || bif.req !== 1'b1) busy_cnt++;
    end
    chk("idle_quiet", busy_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xe1ap_host.md
Name: xe1ap_host

Overview:
- Host-side reader for the XE-1AP / CyberStick / XE-1AJ analog joystick protocol.
- Drives REQ (pin 8), watches ACK (pin 7) and LO_HI (pin 6), and captures the 12-nybble frame from DATA[3:0] (pins 4..1).
- Decodes the frame into buttons and three 8-bit channels.
- Sits between a user-port/SNAC pad connector and core logic, so a real stick can feed the core. It is also the bench master for the core's device emulator.

Parameters:
- CLKPERUSEC, 50, clk_sys cycles per microsecond; all timing derives from it.
- REQ_MIN_US, 4, minimum REQ low time before release is permitted.
- TIMEOUT_US, 250, maximum wait for any ACK falling edge before abort.
- POLL_US, 16000, auto-poll period (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin a frame read (ignored while busy)
- speed_sel  in  2  requested protocol speed, 0 = fastest, 3 = slowest
- ack_in  in  1  pad ACK, asynchronous
- lo_hi_in  in  1  pad LO_HI, asynchronous
- data_in  in  4  pad DATA[3:0], asynchronous
- req  out  1  to pad REQ; idle high
- busy  out  1  frame in progress
- valid  out  1  one-cycle pulse when a frame passes all checks
- frame_err  out  1  one-cycle pulse on timeout or check failure
- buttons  out  12  active-high pressed: [0]A [1]B [2]C [3]D [4]E1 [5]E2 [6]Start [7]Select [8]A [9]B [10]A' [11]B'
- ch0_y  out  8  unsigned Y, 0x00 = up
- ch1_x  out  8  unsigned X, 0x00 = left
- ch2_thr  out  8  unsigned throttle, 0xFF = up

Behaviour:
- Input sync: ack_in, lo_hi_in and data_in each pass through a 2-FF synchronizer. Edge detection uses the synchronized ACK and its one-cycle-delayed copy. Data is sampled from the synchronized bus in the same cycle the ACK falling edge is detected.
- Reset values: req=1, busy=0, valid=0, frame_err=0, buttons=0, ch0_y=ch1_x=ch2_thr=8'h80, state IDLE. Reset during a frame aborts it immediately with no valid or frame_err pulse.
- IDLE:
  - On start, clear nybble index n=0, drive req=0, set busy=1, go to REQ_LOW.
  - A start that arrives while busy is dropped.
- REQ_LOW: after REQ_MIN_US elapses, go to CAPTURE. REQ stays low.
- CAPTURE:
  - On each ACK falling edge: store data into nybble[n], check lo_hi against expected (0 for even n, 1 for odd n), increment n, reload the timeout counter.
  - REQ release for speed selection: req goes to 1 on the ACK falling edge where n == 2*speed_sel. The pad then sees REQ high at its cycle (speed_sel+1) check and settles on speed speed_sel. For speed_sel=3, req releases at n=6 (the pad defaults to slowest).
  - After nybble 11 is stored, go to CHECK.
  - If no ACK falling edge arrives within TIMEOUT_US, go to ABORT.
- CHECK: frame passes when all of the following hold:
  - nybble[5]==0
  - nybble[9]==0
  - nybble[11]==4'hF
  - no lo_hi mismatch occurred
- CHECK, pass: update outputs in one cycle, assert valid for 1 cycle, go to DRAIN.
  - ch0_y = {n[2], n[6]}, ch1_x = {n[3], n[7]}, ch2_thr = {n[4], n[8]}.
  - buttons = ~{n[10][0], n[10][1], n[10][2], n[10][3], n[1][1], n[1][0], n[1][2], n[1][3], n[0][0], n[0][1], n[0][2], n[0][3]}.
  - In the 12-bit button vector above, nybble bit 3 maps to the lower index within each group; MSB is listed first.
- CHECK, fail: outputs hold previous values, frame_err pulses, go to DRAIN.
- DRAIN: wait for synchronized ACK=1 and LO_HI=0 (or TIMEOUT_US), then busy=0, go to IDLE.
- ABORT: req=1, frame_err pulse, go to DRAIN.
- Counters: a microsecond prescaler counts 0..CLKPERUSEC-1. The microsecond counter is 9 bits and saturates without wrapping.
- valid and frame_err never assert in the same cycle.
- speed_sel is latched on start; changes mid-frame are ignored.

Optional Feature:
- XE1AP_HOST_AUTOPOLL_EN defined:
  - An internal POLL_US timer generates a start every POLL_US while idle.
  - The external start is still OR-ed in.
  - The timer restarts when a frame completes.
- Undefined: reads happen only on the external start; no poll timer logic is present.

Decomposition:
- Package xe1ap_pkg holds:
  - state enum (IDLE, REQ_LOW, CAPTURE, CHECK, DRAIN, ABORT)
  - nybble index constants (NYB_BTN1=0, NYB_BTN2=1, NYB_PAD0=5, NYB_PAD1=9, NYB_BTN3=10, NYB_END=11)
  - END_NYBBLE=4'hF
  - the button bit-position constants
- One sub-module, xe1ap_usec_timer: prescaler plus saturating microsecond counter with clear. It is shared by the REQ_LOW, timeout and autopoll timers.

Test Plan:
- Bench pad model at speed 3, Y=8'h12, X=8'hA5, throttle=8'hF0, A pressed, speed_sel=3, start -> after 12 ACKs: valid=1, ch0_y=12, ch1_x=A5, ch2_thr=F0, buttons=12'h101; req rises at nybble 6.
- speed_sel=0 with pad model -> req rises at the first ACK falling edge; the next frame uses speed-0 timing (about 50 µs per cycle); valid still asserts.
- Pad stops after nybble 4 -> frame_err pulse about 250 µs after the last ACK; req=1; busy clears; axis outputs unchanged.
- Corrupt nybble 11 to 4'hE -> frame_err pulse, no valid, outputs hold prior frame values.
- Assert reset at nybble 7 -> next cycle req=1, busy=0, axes=8'h80, no pulses; a fresh start then completes normally.
- With XE1AP_HOST_AUTOPOLL_EN, POLL_US=2000, no start -> valid pulses about every 2 ms; without the macro -> no activity.
